decode_issue_stage: RTL and testbench

- ID-to-EX stage directly upstream of the ALU.
- Accepts 32-bit MIPS instructions from fetch over a valid/ready handshake, reads the register file, and decodes the ALU control word.
- Produces operands src1/src2 and a destination, and holds them in a registered output slot consumed by the ALU/EX stage.
- A 32-entry scoreboard stalls issue on RAW hazards until writeback, with a same-cycle writeback bypass.

---
 rtl/mips_pkg.sv | 76 +++++++
 rtl/decode_issue_stage_scoreboard.sv | 42 ++++
 rtl/decode_issue_stage.sv | 109 ++++++++++
 tb/tb_decode_issue_stage.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS decode definitions: opcodes, ALU control word, immediate
// extension kinds and the instruction field decoder used by ID and EX.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  typedef logic [11:0] ctrl_t;

  typedef enum logic [1:0] {EXT_SIGN, EXT_ZERO, EXT_NONE} ext_t;

  typedef struct packed {
    ctrl_t      ctrl;
    ext_t       ext;
    logic       use_rs;
    logic       use_rt;
    logic [4:0] dest;
    logic       wen;
    logic       illegal;
  } dec_t;

  function automatic dec_t decode(input logic [31:0] instr);
    dec_t       d;
    logic [5:0] op;
    logic [5:0] funct;
    op       = instr[31:26];
    funct    = instr[5:0];
    d.ctrl   = {op, (op == OP_RTYPE) ? funct : 6'b0};
    d.ext    = EXT_NONE;
    d.use_rs = 1'b0;
    d.use_rt = 1'b0;
    d.dest   = 5'd0;
    d.wen    = 1'b0;
    d.illegal = 1'b0;
    case (op)
      OP_RTYPE: begin
        d.use_rs = 1'b1;
        d.use_rt = 1'b1;
        d.dest   = instr[15:11];
        d.wen    = 1'b1;
      end
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_LW: begin
        d.ext    = EXT_SIGN;
        d.use_rs = 1'b1;
        d.dest   = instr[20:16];
        d.wen    = 1'b1;
      end
      OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
        d.ext    = EXT_ZERO;
        d.use_rs = 1'b1;
        d.dest   = instr[20:16];
        d.wen    = 1'b1;
      end
      OP_SW, OP_BEQ, OP_BNE: begin
        d.use_rs = 1'b1;
        d.use_rt = 1'b1;
      end
      default: d.illegal = 1'b1;
    endcase
    // Register 0 is hardwired, so a write to it is dropped entirely.
    if (d.dest == 5'd0) d.wen = 1'b0;
    return d;
  endfunction

endpackage

// File: rtl/decode_issue_stage_scoreboard.sv
// Pending-write mask: one bit per architectural register, set on issue and
// cleared on writeback or when the issuing slot is flushed.
module decode_issue_stage_scoreboard
  import mips_pkg::*;
#(
  parameter int NREGS = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       set_en,
  input  logic [4:0] set_addr,
  input  logic       clr_en,
  input  logic [4:0] clr_addr,
  input  logic       kill_en,
  input  logic [4:0] kill_addr,
  input  logic [4:0] look_addr1,
  input  logic [4:0] look_addr2,
  output logic       pend1,
  output logic       pend2
);

  logic [NREGS-1:0] pend;
  logic [NREGS-1:0] pend_next;

  // Set is applied last so a same-cycle set and clear leaves the bit pending.
  always_comb begin
    pend_next = pend;
    if (clr_en)  pend_next[clr_addr]  = 1'b0;
    if (kill_en) pend_next[kill_addr] = 1'b0;
    if (set_en)  pend_next[set_addr]  = 1'b1;
    pend_next[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) pend <= '0;
    else     pend <= pend_next;
  end

  assign pend1 = pend[look_addr1];
  assign pend2 = pend[look_addr2];

endmodule

// File: rtl/decode_issue_stage.sv
// ID-to-EX stage: decodes a MIPS instruction, reads operands with writeback
// bypass, stalls on RAW hazards and holds the result in a registered slot.
module decode_issue_stage
  import mips_pkg::*;
#(
  parameter int NREGS  = 32,
  parameter int CTRL_W = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_instr,
  output logic [4:0]        rf_raddr1,
  output logic [4:0]        rf_raddr2,
  input  logic [31:0]       rf_rdata1,
  input  logic [31:0]       rf_rdata2,
  input  logic              wb_valid,
  input  logic [4:0]        wb_addr,
  input  logic [31:0]       wb_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [31:0]       out_src1,
  output logic [31:0]       out_src2,
  output logic [4:0]        out_dest,
  output logic              out_wen,
  output logic              out_illegal
);

  dec_t        dec;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [15:0] imm;
  logic [31:0] rd1;
  logic [31:0] rd2;
  logic [31:0] src1;
  logic [31:0] src2;
  logic        pend1;
  logic        pend2;
  logic        hazard;
  logic        accept;

  assign dec       = decode(in_instr);
  assign rs        = in_instr[25:21];
  assign rt        = in_instr[20:16];
  assign imm       = in_instr[15:0];
  assign rf_raddr1 = rs;
  assign rf_raddr2 = rt;

  // A writeback to a source this cycle both supplies its value and resolves
  // the pending bit, so the consumer issues without an extra bubble.
  always_comb begin
    rd1 = (rs == 5'd0) ? 32'd0 : ((wb_valid && wb_addr == rs) ? wb_data : rf_rdata1);
    rd2 = (rt == 5'd0) ? 32'd0 : ((wb_valid && wb_addr == rt) ? wb_data : rf_rdata2);
    hazard = (dec.use_rs && rs != 5'd0 && pend1 && !(wb_valid && wb_addr == rs)) ||
             (dec.use_rt && rt != 5'd0 && pend2 && !(wb_valid && wb_addr == rt));
    src1 = dec.illegal ? 32'd0 : rd1;
    case (dec.ext)
      EXT_SIGN: src2 = {{16{imm[15]}}, imm};
      EXT_ZERO: src2 = {16'd0, imm};
      default:  src2 = dec.illegal ? 32'd0 : rd2;
    endcase
  end

  assign in_ready = !rst && !flush && !hazard && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;

  decode_issue_stage_scoreboard #(.NREGS(NREGS)) u_scoreboard (
    .clk        (clk),
    .rst        (rst),
    .set_en     (accept && dec.wen),
    .set_addr   (dec.dest),
    .clr_en     (wb_valid),
    .clr_addr   (wb_addr),
    .kill_en    (flush && out_valid && out_wen),
    .kill_addr  (out_dest),
    .look_addr1 (rs),
    .look_addr2 (rt),
    .pend1      (pend1),
    .pend2      (pend2)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid   <= 1'b0;
      out_ctrl    <= '0;
      out_src1    <= '0;
      out_src2    <= '0;
      out_dest    <= '0;
      out_wen     <= 1'b0;
      out_illegal <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid   <= 1'b1;
      out_ctrl    <= dec.ctrl;
      out_src1    <= src1;
      out_src2    <= src2;
      out_dest    <= dec.dest;
      out_wen     <= dec.wen;
      out_illegal <= dec.illegal;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_decode_issue_stage.sv
// Directed bench for decode_issue_stage: expected issue records are queued
// when an instruction is offered and compared when EX consumes the slot.
module tb_decode_issue_stage;
  import mips_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [4:0]  rf_raddr1;
  logic [4:0]  rf_raddr2;
  logic [31:0] rf_rdata1;
  logic [31:0] rf_rdata2;
  logic        wb_valid;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [11:0] out_ctrl;
  logic [31:0] out_src1;
  logic [31:0] out_src2;
  logic [4:0]  out_dest;
  logic        out_wen;
  logic        out_illegal;

  typedef struct {
    logic [11:0] ctrl;
    logic [31:0] src1;
    logic [31:0] src2;
    logic [4:0]  dest;
    logic        wen;
    logic        illegal;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  decode_issue_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
    .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2), .wb_valid(wb_valid),
    .wb_addr(wb_addr), .wb_data(wb_data), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl),
    .out_src1(out_src1), .out_src2(out_src2), .out_dest(out_dest),
    .out_wen(out_wen), .out_illegal(out_illegal)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic push(input logic [11:0] c, input logic [31:0] s1, input logic [31:0] s2,
                      input logic [4:0] d, input logic w, input logic ill);
    exp_t e;
    e.ctrl = c; e.src1 = s1; e.src2 = s2; e.dest = d; e.wen = w; e.illegal = ill;
    exp_q.push_back(e);
  endtask

  task automatic check_front(input string tag);
    exp_t e;
    if (exp_q.size() == 0) begin
      check({tag, "_unexpected"}, 32'd1, 32'd0);
    end else begin
      e = exp_q[0];
      check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
      check({tag, "_ctrl"}, {20'd0, out_ctrl}, {20'd0, e.ctrl});
      check({tag, "_src1"}, out_src1, e.src1);
      check({tag, "_src2"}, out_src2, e.src2);
      check({tag, "_dest"}, {27'd0, out_dest}, {27'd0, e.dest});
      check({tag, "_wen"}, {31'd0, out_wen}, {31'd0, e.wen});
      check({tag, "_illegal"}, {31'd0, out_illegal}, {31'd0, e.illegal});
    end
  endtask

  // Consumption is sampled on the falling edge; the rising edge moves state.
  task automatic tick();
    @(negedge clk);
    if (out_valid && out_ready) begin
      check_front("consume");
      if (exp_q.size() != 0) void'(exp_q.pop_front());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [31:0] instr);
    in_instr = instr;
    in_valid = 1'b1;
    #1;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_instr = 32'd0; rf_rdata1 = 32'd0; rf_rdata2 = 32'd0;
    wb_valid = 1'b0; wb_addr = 5'd0; wb_data = 32'd0; flush = 1'b0; out_ready = 1'b1;
    #1;
    check("ready_in_reset", {31'd0, in_ready}, 32'd0);
    tick(); tick();
    check("reset_valid", {31'd0, out_valid}, 32'd0);
    check("reset_ctrl", {20'd0, out_ctrl}, 32'd0);
    check("reset_src", out_src1 | out_src2, 32'd0);
    check("reset_dest_wen", {26'd0, out_dest, out_wen}, 32'd0);
    rst = 1'b0;

    // addiu $8,$0,5 with one-cycle latency
    offer(32'h24080005);
    check("addiu_ready", {31'd0, in_ready}, 32'd1);
    push(12'b001001_000000, 32'd0, 32'd5, 5'd8, 1'b1, 1'b0);
    tick();
    check("addiu_latency", {31'd0, out_valid}, 32'd1);

    // addu $9,$8,$8 stalls on $8 until its writeback arrives
    offer(32'h01084821);
    check("raw_stall0", {31'd0, in_ready}, 32'd0);
    tick();
    check("raw_slot_drained", {31'd0, out_valid}, 32'd0);
    check("raw_stall1", {31'd0, in_ready}, 32'd0);
    tick();
    wb_valid = 1'b1; wb_addr = 5'd8; wb_data = 32'h2A;
    #1;
    check("raw_bypass_ready", {31'd0, in_ready}, 32'd1);
    push(12'b000000_100001, 32'h2A, 32'h2A, 5'd9, 1'b1, 1'b0);
    tick();
    wb_valid = 1'b0;

    offer(32'h2401FFFF);
    push(12'b001001_000000, 32'd0, 32'hFFFFFFFF, 5'd1, 1'b1, 1'b0);
    tick();
    offer(32'h3401FFFF);
    push(12'b001101_000000, 32'd0, 32'h0000FFFF, 5'd1, 1'b1, 1'b0);
    tick();

    // addu $3,$4,$5 reads the register file on both ports
    rf_rdata1 = 32'h1111; rf_rdata2 = 32'h2222;
    offer(32'h00851821);
    check("raddr1", {27'd0, rf_raddr1}, 32'd4);
    check("raddr2", {27'd0, rf_raddr2}, 32'd5);
    push(12'b000000_100001, 32'h1111, 32'h2222, 5'd3, 1'b1, 1'b0);
    tick();
    offer(32'hAC850010);
    push(12'b101011_000000, 32'h1111, 32'h2222, 5'd0, 1'b0, 1'b0);
    tick();
    offer(32'hFC000000);
    push(12'b111111_000000, 32'd0, 32'd0, 5'd0, 1'b0, 1'b1);
    tick();
    offer(32'h3C028000);
    push(12'b001111_000000, 32'd0, 32'h00008000, 5'd2, 1'b1, 1'b0);
    tick();
    offer(32'h28068000);
    push(12'b001010_000000, 32'd0, 32'hFFFF8000, 5'd6, 1'b1, 1'b0);
    tick();
    offer(32'h24000003);
    push(12'b001001_000000, 32'd0, 32'd3, 5'd0, 1'b0, 1'b0);
    tick();
    rf_rdata1 = 32'd0; rf_rdata2 = 32'd0;

    // Backpressure: slot holds addiu $7 for three cycles
    offer(32'h24070007);
    push(12'b001001_000000, 32'd0, 32'd7, 5'd7, 1'b1, 1'b0);
    tick();
    out_ready = 1'b0;
    offer(32'h240A000A);
    for (int i = 0; i < 3; i++) begin
      check("bp_ready", {31'd0, in_ready}, 32'd0);
      check_front("bp_hold");
      tick();
    end
    out_ready = 1'b1;
    #1;
    check("bp_release_ready", {31'd0, in_ready}, 32'd1);
    push(12'b001001_000000, 32'd0, 32'd10, 5'd10, 1'b1, 1'b0);
    tick();
    check("bp_next_loaded", {27'd0, out_dest}, 32'd10);

    // Flush kills a held addiu $8 and releases its pending bit
    offer(32'h24080005);
    push(12'b001001_000000, 32'd0, 32'd5, 5'd8, 1'b1, 1'b0);
    tick();
    out_ready = 1'b0; in_valid = 1'b0;
    tick();
    flush = 1'b1;
    offer(32'h01084821);
    check("flush_ready", {31'd0, in_ready}, 32'd0);
    tick();
    flush = 1'b0;
    if (exp_q.size() != 0) void'(exp_q.pop_front());
    check("flush_valid", {31'd0, out_valid}, 32'd0);
    out_ready = 1'b1;
    offer(32'h01084821);
    check("post_flush_no_stall", {31'd0, in_ready}, 32'd1);
    push(12'b000000_100001, 32'd0, 32'd0, 5'd9, 1'b1, 1'b0);
    tick();
    in_valid = 1'b0;
    tick(); tick();
    check("queue_drained", exp_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
